// File: rtl/psum_in_bus_ctrl.sv
// Feeds one horizontal psum bus: buffers global-buffer psums and broadcasts each
// one only once every masked PE reports ready, counting beats per pass.
`timescale 1ns/1ps
module psum_in_bus_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned NUM_PE     = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  config_state,
    input  logic                  ce,
    input  logic [ID_WIDTH-1:0]   cfg_row_id,
    input  logic [NUM_PE-1:0]     cfg_pe_mask,
    input  logic [CNT_WIDTH-1:0]  cfg_psum_len,
    input  logic [DATA_WIDTH-1:0] gb_psum_data,
    input  logic                  gb_psum_valid,
    output logic                  gb_psum_ready,
    input  logic [NUM_PE-1:0]     pe_ready_vec,
    output logic [ID_WIDTH-1:0]   bus_source_id,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_data_valid,
    output logic                  pass_done,
    output logic                  busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RDY = 2'd1,
        S_HOLD     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_row_id;
    logic [NUM_PE-1:0]     r_mask;
    logic [CNT_WIDTH-1:0]  r_len;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [OCC_W-1:0]      r_occ;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_done;
    logic                  w_all_rdy;

    assign w_full        = (r_occ == OCC_W'(FIFO_DEPTH));
    assign w_empty       = (r_occ == '0);
    assign gb_psum_ready = !w_full && !config_state;
    assign w_push        = gb_psum_valid && gb_psum_ready;
    assign w_all_rdy     = (&(pe_ready_vec | ~r_mask)) && (r_mask != '0);
    assign w_cnt_inc     = r_cnt + CNT_WIDTH'(1);

    // Configuration latch and registered bus id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_id      <= '0;
            r_mask        <= '0;
            r_len         <= '0;
            bus_source_id <= '0;
        end else begin
            if (config_state && ce) begin
                r_row_id <= cfg_row_id;
                r_mask   <= cfg_pe_mask;
                r_len    <= cfg_psum_len;
            end
            bus_source_id <= r_row_id;
        end
    end

    // Psum storage; head is read only after the write edge, so no bypass.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= gb_psum_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else if (config_state) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

    // State register and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            bus_data       <= '0;
            bus_data_valid <= 1'b0;
            pass_done      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            bus_data_valid <= w_pop;
            pass_done      <= w_done;
            busy           <= (w_state_nxt != S_IDLE);
            if (w_pop) begin
                bus_data <= r_mem[r_rptr];
            end
        end
    end

    // HOLD demands ready drop low before the next beat, so a held level issues once.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        if (config_state) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: begin
                    if ((r_len != '0) && !w_empty) begin
                        w_state_nxt = S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (w_all_rdy && !w_empty) begin
                        w_pop       = 1'b1;
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = (w_cnt_inc == r_len) ? S_DONE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!w_all_rdy) begin
                        w_state_nxt = S_WAIT_RDY;
                    end
                end
                S_DONE: begin
                    w_done      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_in_bus_ctrl.sv
// Bench for psum_in_bus_ctrl: directed scenarios plus randomized traffic checked
// by a transaction-level model (psum queue, per-pass beat count, ready rules).
`timescale 1ns/1ps
module tb_psum_in_bus_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 8;
    localparam int unsigned NP = 12;
    localparam int unsigned FD = 4;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          rst_n;
    logic          config_state;
    logic          ce;
    logic [IW-1:0] cfg_row_id;
    logic [NP-1:0] cfg_pe_mask;
    logic [CW-1:0] cfg_psum_len;
    logic [DW-1:0] gb_psum_data;
    logic          gb_psum_valid;
    logic          gb_psum_ready;
    logic [NP-1:0] pe_ready_vec;
    logic [IW-1:0] bus_source_id;
    logic [DW-1:0] bus_data;
    logic          bus_data_valid;
    logic          pass_done;
    logic          busy;

    int            n_checks;
    int            n_fail;
    logic [NP-1:0] m_mask;
    logic [CW-1:0] m_len;
    logic          mon_en;
    logic [DW-1:0] mq[$];
    int            m_beats;
    logic          m_pending;
    logic          m_armed;
    logic          m_p_ce;
    logic          m_p_rdy;
    logic          m_cur_rdy;
    logic [DW-1:0] m_exp;

    psum_in_bus_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .config_state   (config_state),
        .ce             (ce),
        .cfg_row_id     (cfg_row_id),
        .cfg_pe_mask    (cfg_pe_mask),
        .cfg_psum_len   (cfg_psum_len),
        .gb_psum_data   (gb_psum_data),
        .gb_psum_valid  (gb_psum_valid),
        .gb_psum_ready  (gb_psum_ready),
        .pe_ready_vec   (pe_ready_vec),
        .bus_source_id  (bus_source_id),
        .bus_data       (bus_data),
        .bus_data_valid (bus_data_valid),
        .pass_done      (pass_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic all_rdy(input logic [NP-1:0] v);
        return (&(v | ~m_mask)) && (m_mask != '0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reconfig(input logic [IW-1:0] id, input logic [NP-1:0] m, input logic [CW-1:0] l);
        config_state  = 1'b1;
        ce            = 1'b1;
        cfg_row_id    = id;
        cfg_pe_mask   = m;
        cfg_psum_len  = l;
        gb_psum_valid = 1'b0;
        pe_ready_vec  = '0;
        m_mask        = m;
        m_len         = l;
        tick();
        config_state = 1'b0;
        tick();
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        gb_psum_valid = 1'b1;
        gb_psum_data  = d;
        tick();
        gb_psum_valid = 1'b0;
    endtask

    // One ready pulse from WAIT_RDY: beat on the first edge, back to WAIT_RDY on the second.
    task automatic pulse_beat(input string tag, input logic [DW-1:0] exp);
        pe_ready_vec = m_mask;
        tick();
        check_eq({tag, "_valid"}, 32'(bus_data_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(bus_data), 32'(exp));
        pe_ready_vec = '0;
        tick();
        check_eq({tag, "_valid_low"}, 32'(bus_data_valid), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_ready);
        check_eq({tag, "_src_id"}, 32'(bus_source_id), 32'd0);
        check_eq({tag, "_data"}, 32'(bus_data), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus_data_valid), 32'd0);
        check_eq({tag, "_pass_done"}, 32'(pass_done), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_gb_ready"}, 32'(gb_psum_ready), 32'(exp_ready));
    endtask

    // Reference model: psums leave in push order, each beat needs ce and all-ready on
    // the deciding edge, later beats of a pass need ready to have dropped since the
    // previous beat, and pass_done follows the len-th beat on the next enabled edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                mq.delete();
                m_beats   = 0;
                m_pending = 1'b0;
                m_armed   = 1'b0;
                m_p_ce    = 1'b0;
                m_p_rdy   = 1'b0;
            end else begin
                if (pass_done) begin
                    check_eq("done_expected", 32'(m_pending), 32'd1);
                    m_pending = 1'b0;
                    m_beats   = 0;
                end else if (m_pending && m_p_ce) begin
                    check_eq("done_missing", 32'(pass_done), 32'd1);
                    m_pending = 1'b0;
                    m_beats   = 0;
                end
                if (bus_data_valid) begin
                    check_eq("beat_ce", 32'(m_p_ce), 32'd1);
                    check_eq("beat_all_rdy", 32'(m_p_rdy), 32'd1);
                    check_eq("beat_in_done", 32'(m_pending), 32'd0);
                    if (m_beats > 0) check_eq("beat_hold", 32'(m_armed), 32'd1);
                    check_eq("beat_fifo_nonempty", 32'(mq.size() != 0), 32'd1);
                    if (mq.size() != 0) begin
                        m_exp = mq.pop_front();
                        check_eq("beat_data", 32'(bus_data), 32'(m_exp));
                    end
                    m_armed = 1'b0;
                    m_beats++;
                    if (m_beats == int'(m_len)) m_pending = 1'b1;
                end
                check_eq("gb_ready", 32'(gb_psum_ready), 32'(mq.size() < FD));
                if (gb_psum_valid && (mq.size() < FD)) mq.push_back(gb_psum_data);
                m_cur_rdy = all_rdy(pe_ready_vec);
                if (!m_cur_rdy) m_armed = 1'b1;
                m_p_ce  = ce;
                m_p_rdy = m_cur_rdy;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          beats;
        logic [DW-1:0] hold_val;
        n_checks      = 0;
        n_fail        = 0;
        mon_en        = 1'b0;
        rst_n         = 1'b0;
        config_state  = 1'b0;
        ce            = 1'b0;
        cfg_row_id    = '0;
        cfg_pe_mask   = '0;
        cfg_psum_len  = '0;
        gb_psum_data  = '0;
        gb_psum_valid = 1'b0;
        pe_ready_vec  = '0;
        m_mask        = '0;
        m_len         = '0;
        tick();
        tick();
        check_idle_outputs("rst_hold", 1'b1);
        rst_n = 1'b1;
        tick();
        check_idle_outputs("rst_release", 1'b1);

        // Basic pass with two pulsed readies.
        reconfig(8'h05, 12'h003, 8'd2);
        check_eq("t1_src_id", 32'(bus_source_id), 32'h05);
        push_one(16'h1111);
        push_one(16'h2222);
        check_eq("t1_busy", 32'(busy), 32'd1);
        pulse_beat("t1_beat0", 16'h1111);
        check_eq("t1_no_done_mid", 32'(pass_done), 32'd0);
        pulse_beat("t1_beat1", 16'h2222);
        check_eq("t1_pass_done", 32'(pass_done), 32'd1);
        check_eq("t1_busy_drop", 32'(busy), 32'd0);
        tick();
        check_eq("t1_pass_done_once", 32'(pass_done), 32'd0);

        // Held ready level issues only one beat.
        push_one(16'h3333);
        push_one(16'h4444);
        pe_ready_vec = 12'h003;
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_data_valid) begin
                beats++;
                check_eq("t2_first_data", 32'(bus_data), 32'h3333);
            end
        end
        check_eq("t2_beat_count", 32'(beats), 32'd1);
        pe_ready_vec = '0;
        tick();
        pulse_beat("t2_beat1", 16'h4444);
        check_eq("t2_pass_done", 32'(pass_done), 32'd1);
        tick();

        // Partial ready never issues; unmasked bits are ignored.
        push_one(16'h5555);
        for (int i = 0; i < 4; i++) begin
            pe_ready_vec = (i % 2 == 0) ? 12'h021 : 12'h001;
            tick();
            check_eq("t3_no_beat", 32'(bus_data_valid), 32'd0);
        end
        pe_ready_vec = 12'h023;
        tick();
        check_eq("t3_beat_valid", 32'(bus_data_valid), 32'd1);
        check_eq("t3_beat_data", 32'(bus_data), 32'h5555);
        pe_ready_vec = '0;

        // All-zero mask waits forever.
        reconfig(8'h01, 12'h000, 8'd2);
        push_one(16'h0F0F);
        pe_ready_vec = {NP{1'b1}};
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t3_mask0_no_beat", 32'(bus_data_valid), 32'd0);
        end
        check_eq("t3_mask0_busy", 32'(busy), 32'd1);

        // FIFO fill to full, backpressure, then ordered drain.
        reconfig(8'h05, 12'h003, 8'd8);
        gb_psum_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("t4_ready_before_push", 32'(gb_psum_ready), 32'd1);
            gb_psum_data = DW'(16'hA000 + i);
            tick();
        end
        check_eq("t4_full_ready", 32'(gb_psum_ready), 32'd0);
        gb_psum_data = 16'hA004;
        tick();
        tick();
        check_eq("t4_full_held", 32'(gb_psum_ready), 32'd0);
        pe_ready_vec = 12'h003;
        tick();
        check_eq("t4_beat0_valid", 32'(bus_data_valid), 32'd1);
        check_eq("t4_beat0_data", 32'(bus_data), 32'hA000);
        check_eq("t4_ready_after_pop", 32'(gb_psum_ready), 32'd1);
        pe_ready_vec = '0;
        tick();
        check_eq("t4_full_again", 32'(gb_psum_ready), 32'd0);
        gb_psum_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            pulse_beat("t4_drain", DW'(16'hA000 + i));
        end

        // Clock enable low freezes issue.
        reconfig(8'h05, 12'h003, 8'd2);
        push_one(16'h5A5A);
        tick();
        hold_val = 16'hA004;
        ce = 1'b0;
        pe_ready_vec = 12'h003;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t5_ce_low_no_beat", 32'(bus_data_valid), 32'd0);
            check_eq("t5_ce_low_data_hold", 32'(bus_data), 32'(hold_val));
        end
        ce = 1'b1;
        tick();
        check_eq("t5_beat_valid", 32'(bus_data_valid), 32'd1);
        check_eq("t5_beat_data", 32'(bus_data), 32'h5A5A);
        pe_ready_vec = '0;
        tick();

        // Config flush mid-pass, then async reset mid-pass.
        reconfig(8'h05, 12'h003, 8'd4);
        push_one(16'hB000);
        push_one(16'hB001);
        push_one(16'hB002);
        pulse_beat("t6_beat0", 16'hB000);
        config_state = 1'b1;
        tick();
        check_eq("t6_cfg_valid", 32'(bus_data_valid), 32'd0);
        check_eq("t6_cfg_busy", 32'(busy), 32'd0);
        check_eq("t6_cfg_gb_ready", 32'(gb_psum_ready), 32'd0);
        config_state = 1'b0;
        pe_ready_vec = 12'h003;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_flushed_busy", 32'(busy), 32'd0);
            check_eq("t6_flushed_valid", 32'(bus_data_valid), 32'd0);
            check_eq("t6_flushed_done", 32'(pass_done), 32'd0);
        end
        pe_ready_vec = '0;
        push_one(16'hB003);
        push_one(16'hB004);
        push_one(16'hB005);
        pulse_beat("t6_beat1", 16'hB003);
        config_state = 1'b1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_in_reset", 1'b0);
        config_state = 1'b0;
        #1;
        check_eq("t6_reset_gb_ready", 32'(gb_psum_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("t6_after_reset", 1'b1);
        push_one(16'hC000);
        pe_ready_vec = {NP{1'b1}};
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_len0_idle", 32'(busy), 32'd0);
            check_eq("t6_len0_no_beat", 32'(bus_data_valid), 32'd0);
        end
        reconfig(8'h05, 12'h003, 8'd2);
        push_one(16'hC001);
        push_one(16'hC002);
        pulse_beat("t6_post_beat0", 16'hC001);
        pulse_beat("t6_post_beat1", 16'hC002);
        check_eq("t6_post_done", 32'(pass_done), 32'd1);
        tick();

        // Randomized traffic against the reference model.
        for (int r = 0; r < 3; r++) begin
            mon_en = 1'b0;
            tick();
            reconfig(IW'($urandom), NP'($urandom_range(1, 4095)), CW'($urandom_range(1, 4)));
            mon_en = 1'b1;
            for (int c = 0; c < 400; c++) begin
                gb_psum_valid = 1'($urandom_range(0, 1));
                gb_psum_data  = DW'($urandom);
                ce            = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 2))
                    0:       pe_ready_vec = m_mask | NP'($urandom);
                    1:       pe_ready_vec = '0;
                    default: pe_ready_vec = NP'($urandom);
                endcase
                tick();
            end
            gb_psum_valid = 1'b0;
            ce = 1'b1;
            for (int c = 0; c < 200; c++) begin
                pe_ready_vec = (c % 2 == 0) ? m_mask : '0;
                tick();
            end
            check_eq("rand_drain_empty", 32'(mq.size()), 32'd0);
        end
        mon_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_in_bus_ctrl.md
Name: psum_in_bus_ctrl

Overview:
- Upstream feeder of the per-PE psum input routers on one horizontal psum bus.
- Buffers partial sums arriving from the global buffer in a small FIFO.
- Broadcasts each psum on the bus, tagged with the bus source id, only after every targeted PE has raised its ready flag (MAC finished).
- Counts beats per pass and signals pass completion.

Parameters:
- DATA_WIDTH, 16, psum width on the global-buffer side and the bus side.
- ID_WIDTH, 8, width of the source id driven on the bus.
- NUM_PE, 12, number of PEs on the bus; width of the ready and mask vectors.
- FIFO_DEPTH, 4, psum FIFO entries; power of two, at least 2.
- CNT_WIDTH, 8, width of the per-pass beat counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- config_state  in  1  configuration phase
- ce  in  1  clock enable for the FSM and pops
- cfg_row_id  in  ID_WIDTH  source id for this bus; latched during config
- cfg_pe_mask  in  NUM_PE  PEs whose ready is required; latched during config
- cfg_psum_len  in  CNT_WIDTH  psums per pass; latched during config
- gb_psum_data  in  DATA_WIDTH  psum from the global buffer
- gb_psum_valid  in  1  global-buffer psum valid
- gb_psum_ready  out  1  FIFO can accept a psum
- pe_ready_vec  in  NUM_PE  per-PE ready from the routers
- bus_source_id  out  ID_WIDTH  id broadcast on the bus
- bus_data  out  DATA_WIDTH  psum broadcast on the bus
- bus_data_valid  out  1  one-cycle bus beat strobe
- pass_done  out  1  one-cycle pulse after the last beat of a pass
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - All outputs 0, except gb_psum_ready = 1.
  - FIFO empty, counter 0, FSM in IDLE.
  - Latched configuration registers are 0.
- Configuration:
  - When config_state && ce, latch cfg_row_id, cfg_pe_mask and cfg_psum_len.
  - bus_source_id is a register that takes the latched id on the next edge.
  - config_state = 1 at any time (ce not required) does all of the following:
    - forces the FSM to IDLE;
    - flushes the FIFO;
    - clears the counter;
    - holds gb_psum_ready = 0;
    - deasserts bus_data_valid.
- FIFO:
  - A push occurs when gb_psum_valid && gb_psum_ready.
  - gb_psum_ready = !full && !config_state, derived combinationally from the occupancy register.
  - No write-through bypass: data pushed at edge t is visible at the head after edge t.
  - A simultaneous push and pop is legal when not full; occupancy is unchanged.
  - Push is independent of ce.
- all_rdy = (&(pe_ready_vec | ~mask)) && (mask != 0).
- FSM states:
  - IDLE:
    - Go to WAIT_RDY when ce && !config_state && len != 0 && FIFO non-empty.
    - With len = 0, stay in IDLE; no beats and no pass_done.
  - WAIT_RDY:
    - If ce && all_rdy && FIFO non-empty, pop the head and register bus_data = head and bus_data_valid = 1 for exactly one cycle.
    - Increment the counter.
    - Go to DONE if the counter reaches len, otherwise go to HOLD.
  - HOLD:
    - Wait until all_rdy = 0, so a ready level that stays high cannot issue a second beat.
    - Then go to WAIT_RDY.
  - DONE:
    - Pulse pass_done for one cycle.
    - Clear the counter.
    - Go to IDLE.
- ce = 0:
  - FSM, counter and pops are frozen.
  - bus_data_valid is registered to 0.
  - bus_data holds its value.
- Latency: with the FIFO non-empty and all_rdy already high in WAIT_RDY, bus_data_valid rises on the next edge.
- Counter wrap: the counter is CNT_WIDTH wide and compares against len, so it never wraps within a pass.
- A mask of all zeros never issues: the FSM waits in WAIT_RDY until reconfigured.
- busy = (state != IDLE).
- Async reset mid-pass returns everything to reset values immediately.

Test Plan:
1. Config row_id = 0x05, mask = 0x003, len = 2; push 0x1111 and 0x2222; pe_ready_vec = 0x003 pulsed twice.
   - Required: bus_source_id = 0x05.
   - Exactly two single-cycle beats, data 0x1111 then 0x2222.
   - pass_done pulses once, one cycle after the second beat; busy then drops.
2. pe_ready_vec held at 0x003 for 10 cycles with 2 entries queued.
   - Required: only one beat until ready drops and re-rises (HOLD check).
3. Mask 0x003 with pe_ready_vec = 0x001.
   - Required: no beat.
   - After raising bit 1, a beat on the next edge; bit 5 toggling has no effect.
4. Push 5 psums back-to-back with no pops, FIFO_DEPTH = 4.
   - Required: gb_psum_ready falls after the 4th push; the 5th is held until a pop.
   - Order is preserved.
5. Drop ce for 3 cycles while all_rdy = 1 in WAIT_RDY.
   - Required: no beat and no pop during those cycles; the beat follows on the first edge after ce returns.
6. Assert config_state, then rst_n = 0 mid-pass with 2 entries queued.
   - Required: FIFO flushed, FSM in IDLE, counter 0, no pass_done.
   - After reset, all outputs are 0 and gb_psum_ready = 1.
